// File: rtl/pcie_cfg_mgmt_responder.sv
// Configuration-management completer: a small per-function dword store behind the
// cfg_mgmt request/done handshake, with decoded device-control and bus-master outputs.
module pcie_cfg_mgmt_responder #(
   parameter int          FUNC_COUNT     = 1,
   parameter int          REG_DWORDS     = 64,
   parameter logic [15:0] VENDOR_ID      = 16'h1234,
   parameter logic [15:0] DEVICE_ID      = 16'h0001,
   parameter int          PCIE_CAP_DWORD = 28,
   parameter int          RESP_LATENCY   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [9:0]            cfg_mgmt_addr,
   input  logic [7:0]            cfg_mgmt_function_number,
   input  logic                  cfg_mgmt_write,
   input  logic [31:0]           cfg_mgmt_write_data,
   input  logic [3:0]            cfg_mgmt_byte_enable,
   input  logic                  cfg_mgmt_read,
   output logic [31:0]           cfg_mgmt_read_data,
   output logic                  cfg_mgmt_read_write_done,
   output logic [2:0]            cfg_max_payload,
   output logic [2:0]            cfg_max_read_req,
   output logic [FUNC_COUNT-1:0] cfg_bus_master_en,
   output logic                  protocol_error
);

   localparam int DEVCTL = PCIE_CAP_DWORD + 2;

   typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [9:0]              addr_q, addr_d;
   logic [7:0]              func_q, func_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              be_q, be_d;
   logic                    is_wr_q, is_wr_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    done_q, done_d;
   logic [2:0]              mps_q, mps_d;
   logic [2:0]              mrrs_q, mrrs_d;
   logic [FUNC_COUNT-1:0]   bme_q, bme_d;
   logic [31:0]             store_q [FUNC_COUNT][REG_DWORDS];
   logic [31:0]             store_d [FUNC_COUNT][REG_DWORDS];
   logic [31:0]             rd_val;
   logic [31:0]             m;

   function automatic logic [31:0] wr_mask(input int a);
      if (a == 1)      return 32'h0000_0547;
      if (a == DEVCTL) return 32'h0000_70FF;
      if (a >= 48)     return 32'hFFFF_FFFF;
      return 32'h0;
   endfunction

   function automatic logic [31:0] reset_val(input int a);
      if (a == 0)      return {DEVICE_ID, VENDOR_ID};
      if (a == DEVCTL) return 32'h0000_2000;
      return 32'h0;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      func_d  = func_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      is_wr_d = is_wr_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      store_d = store_q;
      rd_val  = 32'h0;
      m       = 32'h0;

      case (state_q)
         IDLE: begin
            if (cfg_mgmt_read || cfg_mgmt_write) begin
               addr_d  = cfg_mgmt_addr;
               func_d  = cfg_mgmt_function_number;
               wdata_d = cfg_mgmt_write_data;
               be_d    = cfg_mgmt_byte_enable;
               is_wr_d = cfg_mgmt_write;
               cnt_d   = 4'(RESP_LATENCY - 1);
               state_d = (RESP_LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = DONE;
         end
         DONE: begin
            state_d = HOLD;
            if (is_wr_q) begin
               for (int f = 0; f < FUNC_COUNT; f++) begin
                  for (int a = 0; a < REG_DWORDS; a++) begin
                     if (addr_q == 10'(a) && func_q == 8'(f)) begin
                        m = wr_mask(a) & {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
                        store_d[f][a] = (store_q[f][a] & ~m) | (wdata_q & m);
                     end
                  end
               end
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Unmatched address/function leaves rd_val at zero, which is the out-of-range read value.
      for (int f = 0; f < FUNC_COUNT; f++) begin
         for (int a = 0; a < REG_DWORDS; a++) begin
            if (addr_d == 10'(a) && func_d == 8'(f)) rd_val = store_q[f][a];
         end
      end

      if (state_d == DONE && state_q != DONE) begin
         done_d = 1'b1;
         if (!is_wr_d) rdata_d = rd_val;
      end

      mps_d  = store_d[0][DEVCTL][7:5];
      mrrs_d = store_d[0][DEVCTL][14:12];
      for (int f = 0; f < FUNC_COUNT; f++) bme_d[f] = store_d[f][1][2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 10'd0;
         func_q  <= 8'd0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         is_wr_q <= 1'b0;
         rdata_q <= 32'h0;
         done_q  <= 1'b0;
         mps_q   <= 3'd0;
         mrrs_q  <= 3'd2;
         bme_q   <= '0;
         for (int f = 0; f < FUNC_COUNT; f++)
            for (int a = 0; a < REG_DWORDS; a++)
               store_q[f][a] <= reset_val(a);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         func_q  <= func_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         mps_q   <= mps_d;
         mrrs_q  <= mrrs_d;
         bme_q   <= bme_d;
         store_q <= store_d;
      end
   end

   assign cfg_mgmt_read_data       = rdata_q;
   assign cfg_mgmt_read_write_done = done_q;
   assign cfg_max_payload          = mps_q;
   assign cfg_max_read_req         = mrrs_q;
   assign cfg_bus_master_en        = bme_q;
   // Flags the conflicting request in the same cycle it is accepted.
   assign protocol_error = (state_q == IDLE) && cfg_mgmt_read && cfg_mgmt_write && !rst;

endmodule

// File: tb/tb_pcie_cfg_mgmt_responder.sv
// Directed bench for pcie_cfg_mgmt_responder with default parameters
// (FUNC_COUNT=1, RESP_LATENCY=2, device control at dword 30).
module tb_pcie_cfg_mgmt_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  cfg_mgmt_addr;
   logic [7:0]  cfg_mgmt_function_number;
   logic        cfg_mgmt_write;
   logic [31:0] cfg_mgmt_write_data;
   logic [3:0]  cfg_mgmt_byte_enable;
   logic        cfg_mgmt_read;
   logic [31:0] cfg_mgmt_read_data;
   logic        cfg_mgmt_read_write_done;
   logic [2:0]  cfg_max_payload;
   logic [2:0]  cfg_max_read_req;
   logic [0:0]  cfg_bus_master_en;
   logic        protocol_error;

   int total = 0;
   int bad   = 0;

   logic [31:0] rd;
   logic [2:0]  hold_mps, hold_mrrs;
   logic [0:0]  hold_bme;
   bit          saw_done;

   pcie_cfg_mgmt_responder dut (
      .clk                      (clk),
      .rst                      (rst),
      .cfg_mgmt_addr            (cfg_mgmt_addr),
      .cfg_mgmt_function_number (cfg_mgmt_function_number),
      .cfg_mgmt_write           (cfg_mgmt_write),
      .cfg_mgmt_write_data      (cfg_mgmt_write_data),
      .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
      .cfg_mgmt_read            (cfg_mgmt_read),
      .cfg_mgmt_read_data       (cfg_mgmt_read_data),
      .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done),
      .cfg_max_payload          (cfg_max_payload),
      .cfg_max_read_req         (cfg_max_read_req),
      .cfg_bus_master_en        (cfg_bus_master_en),
      .protocol_error           (protocol_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // One full transaction; returns the completion data and the decoded outputs seen
   // in the cycle after done, and leaves the DUT back in IDLE.
   task automatic req(input string tag, input bit is_rd, input bit is_wr,
                      input logic [9:0] a, input logic [7:0] fn,
                      input logic [31:0] d, input logic [3:0] be,
                      input bit exp_perr, output logic [31:0] rdata);
      int  lat;
      bit  got;
      @(negedge clk);
      cfg_mgmt_read            = is_rd;
      cfg_mgmt_write           = is_wr;
      cfg_mgmt_addr            = a;
      cfg_mgmt_function_number = fn;
      cfg_mgmt_write_data      = d;
      cfg_mgmt_byte_enable     = be;
      #1;
      check({tag, "_perr"}, 32'(protocol_error), 32'(exp_perr));
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) check({tag, "_perr_pulse"}, 32'(protocol_error), 32'd0);
         if (cfg_mgmt_read_write_done) got = 1'b1;
      end
      check({tag, "_latency"}, 32'(lat), 32'd2);
      rdata = cfg_mgmt_read_data;
      cfg_mgmt_read  = 1'b0;
      cfg_mgmt_write = 1'b0;
      @(posedge clk); #1;
      check({tag, "_done_single"}, 32'(cfg_mgmt_read_write_done), 32'd0);
      check({tag, "_rdata_hold"}, cfg_mgmt_read_data, rdata);
      hold_mps  = cfg_max_payload;
      hold_mrrs = cfg_max_read_req;
      hold_bme  = cfg_bus_master_en;
      @(posedge clk); #1;
   endtask

   initial begin
      rst                      = 1'b1;
      cfg_mgmt_read            = 1'b0;
      cfg_mgmt_write           = 1'b0;
      cfg_mgmt_addr            = 10'd0;
      cfg_mgmt_function_number = 8'd0;
      cfg_mgmt_write_data      = 32'h0;
      cfg_mgmt_byte_enable     = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done",  32'(cfg_mgmt_read_write_done), 32'd0);
      check("rst_rdata", cfg_mgmt_read_data, 32'h0);
      check("rst_perr",  32'(protocol_error), 32'd0);
      check("rst_mps",   32'(cfg_max_payload), 32'd0);
      check("rst_mrrs",  32'(cfg_max_read_req), 32'd2);
      check("rst_bme",   32'(cfg_bus_master_en), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Identity dword.
      req("rd_id", 1, 0, 10'd0, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_id_data", rd, 32'h0001_1234);

      // Device control: MPS=5, MRRS=5.
      req("wr_devctl", 0, 1, 10'd30, 8'd0, 32'h0000_50A0, 4'hF, 0, rd);
      check("devctl_mps",  32'(hold_mps), 32'd5);
      check("devctl_mrrs", 32'(hold_mrrs), 32'd5);
      req("rd_devctl", 1, 0, 10'd30, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_devctl_data", rd, 32'h0000_50A0);

      // Scratch with partial byte enables.
      req("wr_scr_be", 0, 1, 10'd48, 8'd0, 32'hDEAD_BEEF, 4'b0101, 0, rd);
      req("rd_scr_be", 1, 0, 10'd48, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_scr_be_data", rd, 32'h00AD_00EF);

      // Command register mask and bus-master enable.
      req("wr_cmd", 0, 1, 10'd1, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, rd);
      check("cmd_bme", 32'(hold_bme), 32'd1);
      req("rd_cmd", 1, 0, 10'd1, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_cmd_data", rd, 32'h0000_0547);

      // Read-only identity dword ignores writes.
      req("wr_id", 0, 1, 10'd0, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, rd);
      req("rd_id2", 1, 0, 10'd0, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_id2_data", rd, 32'h0001_1234);

      // Out-of-range address and function.
      req("rd_oor", 1, 0, 10'h3FF, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_oor_data", rd, 32'h0);
      req("wr_fn3", 0, 1, 10'd48, 8'd3, 32'h1234_5678, 4'hF, 0, rd);
      req("rd_fn3", 1, 0, 10'd48, 8'd3, 32'h0, 4'h0, 0, rd);
      check("rd_fn3_data", rd, 32'h0);
      req("rd_scr_keep", 1, 0, 10'd48, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_scr_keep_data", rd, 32'h00AD_00EF);

      // Read and write together: treated as a write.
      req("rw_both", 1, 1, 10'd48, 8'd0, 32'hCAFE_F00D, 4'hF, 1, rd);
      req("rd_both", 1, 0, 10'd48, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_both_data", rd, 32'hCAFE_F00D);

      // Reset in the middle of a write.
      @(negedge clk);
      cfg_mgmt_write           = 1'b1;
      cfg_mgmt_addr            = 10'd48;
      cfg_mgmt_function_number = 8'd0;
      cfg_mgmt_write_data      = 32'h1111_1111;
      cfg_mgmt_byte_enable     = 4'hF;
      @(posedge clk); #1;
      rst            = 1'b1;
      cfg_mgmt_write = 1'b0;
      saw_done       = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (cfg_mgmt_read_write_done) saw_done = 1'b1;
      end
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cfg_mgmt_read_write_done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      check("abort_mps",  32'(cfg_max_payload), 32'd0);
      check("abort_mrrs", 32'(cfg_max_read_req), 32'd2);
      check("abort_bme",  32'(cfg_bus_master_en), 32'd0);
      req("rd_after_rst", 1, 0, 10'd48, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_after_rst_data", rd, 32'h0);
      req("rd_devctl_rst", 1, 0, 10'd30, 8'd0, 32'h0, 4'h0, 0, rd);
      check("rd_devctl_rst_data", rd, 32'h0000_2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
